nn_frame_loader: RTL and testbench

Framed byte loader and compute sequencer for the FPGA neural net. It receives a byte stream from the Raspberry Pi GPIO, one byte per `pi_clk` cycle with `write_enable` high. It parses frames into writes on the network's byte-wide weight/input memory and, on request, issues a start pulse to the compute engine. It sits between the GPIO pins and the memory/compute core, and owns the memory write port while a frame is in flight.

---
 rtl/nn_pkg.sv | 22 ++
 rtl/nn_idle_timer.sv | 37 +++
 rtl/nn_frame_loader.sv | 185 ++++++++++++++++++
 tb/tb_nn_frame_loader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and constants for the Pi-to-network frame loader.
package nn_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_LEN  = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4
    } loader_state_e;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_HEADER  = 3'd1,
        ERR_CSUM    = 3'd2,
        ERR_TIMEOUT = 3'd3,
        ERR_BUSY    = 3'd4
    } loader_err_e;

endpackage

// File: rtl/nn_idle_timer.sv
// Counts consecutive enabled cycles; expired is high on the TIMEOUT-th one.
module nn_idle_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic pi_clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired = enable && !clear && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear || expired) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // rst_n is active-high in this codebase despite its name.
    always_ff @(posedge pi_clk or posedge rst_n) begin
        if (rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nn_frame_loader.sv
// Parses framed GPIO bytes into memory writes and issues compute start pulses.
module nn_frame_loader
    import nn_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              pi_clk,
    input  logic              rst_n,
    input  logic [7:0]        gpio_pin,
    input  logic              write_enable,
    input  logic              nn_busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              start,
    output logic              frame_ok,
    output logic              frame_err,
    output logic [2:0]        err_code,
    output logic              loader_busy,
    output logic [2:0]        dbg_state
);

    localparam int         DEPTH    = 2 ** ADDR_W;
    localparam int         CNT_W    = ADDR_W + 1;
    localparam logic [8:0] DEPTH9   = 9'(DEPTH);
    localparam logic [7:0] RSV_MASK = 8'h7F & ~8'((1 << ADDR_W) - 1);

    loader_state_e     state_q;
    logic              go_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [7:0]        xor_q;

    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic              start_q;
    logic              frame_ok_q;
    logic              frame_err_q;
    loader_err_e       err_code_q;
    logic              loader_busy_q;

    logic              tmr_clear;
    logic              tmr_enable;
    logic              tmr_expired;
    logic [8:0]        room;
    logic              len_bad;
    logic              fault;
    loader_err_e       fault_code;

    assign tmr_clear  = (state_q == ST_IDLE) || write_enable;
    assign tmr_enable = (state_q != ST_IDLE) && !write_enable;

    nn_idle_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_idle_timer (
        .pi_clk (pi_clk),
        .rst_n  (rst_n),
        .clear  (tmr_clear),
        .enable (tmr_enable),
        .expired(tmr_expired)
    );

    // Room left from the start address to the top of memory; LEN must fit.
    assign room    = DEPTH9 - 9'(addr_q);
    assign len_bad = (gpio_pin == 8'h00) || ({1'b0, gpio_pin} > room);

    // Busy conflict beats timeout, which beats byte-level errors.
    always_comb begin
        fault      = 1'b0;
        fault_code = ERR_NONE;
        if ((state_q != ST_IDLE) && nn_busy) begin
            fault      = 1'b1;
            fault_code = ERR_BUSY;
        end else if (tmr_expired) begin
            fault      = 1'b1;
            fault_code = ERR_TIMEOUT;
        end else if (write_enable) begin
            case (state_q)
                ST_ADDR: begin
                    if ((gpio_pin & RSV_MASK) != 8'h00) begin
                        fault      = 1'b1;
                        fault_code = ERR_HEADER;
                    end
                end
                ST_LEN: begin
                    if (len_bad) begin
                        fault      = 1'b1;
                        fault_code = ERR_HEADER;
                    end
                end
                ST_CSUM: begin
                    if (gpio_pin != xor_q) begin
                        fault      = 1'b1;
                        fault_code = ERR_CSUM;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge pi_clk or posedge rst_n) begin
        if (rst_n) begin
            state_q       <= ST_IDLE;
            go_q          <= 1'b0;
            addr_q        <= '0;
            cnt_q         <= '0;
            xor_q         <= 8'h00;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= 8'h00;
            start_q       <= 1'b0;
            frame_ok_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            err_code_q    <= ERR_NONE;
            loader_busy_q <= 1'b0;
        end else begin
            mem_we_q    <= 1'b0;
            start_q     <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (fault) begin
                frame_err_q   <= 1'b1;
                err_code_q    <= fault_code;
                state_q       <= ST_IDLE;
                loader_busy_q <= 1'b0;
            end else if (write_enable) begin
                case (state_q)
                    ST_IDLE: begin
                        if ((gpio_pin == SYNC_BYTE) && !nn_busy) begin
                            state_q       <= ST_ADDR;
                            loader_busy_q <= 1'b1;
                        end
                    end
                    ST_ADDR: begin
                        go_q    <= gpio_pin[7];
                        addr_q  <= gpio_pin[ADDR_W-1:0];
                        xor_q   <= gpio_pin;
                        state_q <= ST_LEN;
                    end
                    ST_LEN: begin
                        cnt_q   <= gpio_pin[CNT_W-1:0];
                        xor_q   <= xor_q ^ gpio_pin;
                        state_q <= ST_DATA;
                    end
                    ST_DATA: begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= addr_q;
                        mem_wdata_q <= gpio_pin;
                        addr_q      <= addr_q + 1'b1;
                        cnt_q       <= cnt_q - 1'b1;
                        xor_q       <= xor_q ^ gpio_pin;
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= ST_CSUM;
                        end
                    end
                    ST_CSUM: begin
                        frame_ok_q    <= 1'b1;
                        start_q       <= go_q;
                        err_code_q    <= ERR_NONE;
                        state_q       <= ST_IDLE;
                        loader_busy_q <= 1'b0;
                    end
                    default: begin
                        state_q       <= ST_IDLE;
                        loader_busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign start       = start_q;
    assign frame_ok    = frame_ok_q;
    assign frame_err   = frame_err_q;
    assign err_code    = err_code_q;
    assign loader_busy = loader_busy_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_nn_frame_loader.sv
// Scoreboard bench for nn_frame_loader: expected writes/events queued at drive time.
module tb_nn_frame_loader;

    localparam int         ADDR_W  = 4;
    localparam int         TIMEOUT = 16;
    localparam logic [7:0] SYNC    = 8'hA5;

    logic              pi_clk;
    logic              rst_n;
    logic [7:0]        gpio_pin;
    logic              write_enable;
    logic              nn_busy;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              start;
    logic              frame_ok;
    logic              frame_err;
    logic [2:0]        err_code;
    logic              loader_busy;
    logic [2:0]        dbg_state;

    int n_cmp    = 0;
    int n_bad    = 0;
    int cyc      = 0;
    int byte_cyc = 0;

    logic [31:0] wr_q[$];
    logic [31:0] ev_q[$];

    nn_frame_loader #(
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .pi_clk      (pi_clk),
        .rst_n       (rst_n),
        .gpio_pin    (gpio_pin),
        .write_enable(write_enable),
        .nn_busy     (nn_busy),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .start       (start),
        .frame_ok    (frame_ok),
        .frame_err   (frame_err),
        .err_code    (err_code),
        .loader_busy (loader_busy),
        .dbg_state   (dbg_state)
    );

    // clock / cycle counter
    initial pi_clk = 1'b0;
    always #5 pi_clk = ~pi_clk;
    always @(posedge pi_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // driver tasks: inputs change on the falling edge
    task automatic send(input logic [7:0] b);
        @(negedge pi_clk);
        write_enable = 1'b1;
        gpio_pin     = b;
        byte_cyc     = cyc + 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge pi_clk);
            write_enable = 1'b0;
            gpio_pin     = 8'h00;
        end
    endtask

    task automatic push_wr(input int at, input logic [7:0] addr, input logic [7:0] data);
        wr_q.push_back({at[15:0], addr, data});
    endtask

    task automatic push_ev(input int at, input logic ok, input logic st, input logic er,
                           input logic [2:0] code);
        ev_q.push_back({at[15:0], 10'd0, ok, st, er, code});
    endtask

    // Well-formed frame; bad=1 sends an inverted checksum.
    task automatic frame(input logic [7:0] hdr, input int len, input logic [7:0] pl[16],
                         input bit bad);
        logic [7:0] x;
        x = hdr ^ 8'(len);
        send(SYNC);
        send(hdr);
        send(8'(len));
        for (int i = 0; i < len; i++) begin
            send(pl[i]);
            push_wr(byte_cyc, 8'(hdr[ADDR_W-1:0]) + 8'(i), pl[i]);
            x = x ^ pl[i];
        end
        send(bad ? ~x : x);
        if (bad) push_ev(byte_cyc, 1'b0, 1'b0, 1'b1, 3'd2);
        else     push_ev(byte_cyc, 1'b1, hdr[7], 1'b0, 3'd0);
    endtask

    // scoreboard: every write/pulse must match the head of its queue, cycle included
    initial begin
        logic [31:0] exp;
        forever begin
            @(posedge pi_clk);
            #1;
            if (mem_we) begin
                exp = (wr_q.size() != 0) ? wr_q.pop_front() : 32'hFFFF_FFFF;
                chk("mem_write", {cyc[15:0], 8'(mem_addr), mem_wdata}, exp);
            end
            if (frame_ok || frame_err || start) begin
                exp = (ev_q.size() != 0) ? ev_q.pop_front() : 32'hFFFF_FFFF;
                chk("frame_event", {cyc[15:0], 10'd0, frame_ok, start, frame_err, err_code}, exp);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] pl[16];
        int         a;
        int         len;
        logic       go;

        rst_n        = 1'b1;
        write_enable = 1'b0;
        nn_busy      = 1'b0;
        gpio_pin     = 8'h00;
        for (int i = 0; i < 16; i++) pl[i] = 8'h00;
        repeat (2) @(negedge pi_clk);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_frame_ok", 32'(frame_ok), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_busy", 32'(loader_busy), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b0;
        idle(2);

        // basic multi-byte frame, no GO
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        frame(8'h02, 3, pl, 1'b0);
        idle(1);
        chk("t1_err_code", 32'(err_code), 32'd0);
        chk("t1_idle", 32'(loader_busy), 32'd0);

        // GO frame, then bad checksum back-to-back
        pl[0] = 8'h7F;
        frame(8'h80, 1, pl, 1'b0);
        frame(8'h80, 1, pl, 1'b1);
        idle(1);
        chk("csum_code", 32'(err_code), 32'd2);
        idle(3);
        chk("csum_sticky", 32'(err_code), 32'd2);
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        frame(8'h02, 3, pl, 1'b0);
        idle(1);
        chk("csum_cleared", 32'(err_code), 32'd0);

        // header errors: LEN too long, reserved bit, LEN zero
        send(SYNC); send(8'h0E); send(8'h03);
        push_ev(byte_cyc, 1'b0, 1'b0, 1'b1, 3'd1);
        send(8'h11); send(8'h22);
        idle(1);
        chk("hdr_len_code", 32'(err_code), 32'd1);
        send(SYNC); send(8'h40);
        push_ev(byte_cyc, 1'b0, 1'b0, 1'b1, 3'd1);
        send(SYNC); send(8'h00); send(8'h00);
        push_ev(byte_cyc, 1'b0, 1'b0, 1'b1, 3'd1);
        idle(1);
        chk("hdr_idle", 32'(loader_busy), 32'd0);
        // longest legal frame at the top of memory
        pl[0] = 8'hAA; pl[1] = 8'hBB;
        frame(8'h0E, 2, pl, 1'b0);
        idle(1);

        // timeout expires exactly TIMEOUT cycles after the last byte
        send(SYNC); send(8'h00);
        push_ev(byte_cyc + TIMEOUT, 1'b0, 1'b0, 1'b1, 3'd3);
        idle(TIMEOUT);
        idle(2);
        chk("to_code", 32'(err_code), 32'd3);
        chk("to_idle", 32'(loader_busy), 32'd0);

        // a byte on the would-be expiry cycle keeps the frame alive
        send(SYNC); send(8'h00); send(8'h01);
        idle(TIMEOUT - 1);
        chk("to_hold_busy", 32'(loader_busy), 32'd1);
        send(8'h55);
        push_wr(byte_cyc, 8'h00, 8'h55);
        idle(TIMEOUT - 1);
        send(8'h54);
        push_ev(byte_cyc, 1'b1, 1'b0, 1'b0, 3'd0);
        idle(1);
        chk("to_recover_code", 32'(err_code), 32'd0);

        // bytes dropped in IDLE while compute runs
        nn_busy = 1'b1;
        send(SYNC); send(8'h00); send(8'h01); send(8'h55); send(8'h54);
        idle(2);
        chk("busy_drop_idle", 32'(loader_busy), 32'd0);
        nn_busy = 1'b0;
        idle(1);

        // busy conflict mid-frame drops the presented byte
        send(SYNC); send(8'h00); send(8'h02); send(8'h55);
        push_wr(byte_cyc, 8'h00, 8'h55);
        @(negedge pi_clk);
        nn_busy      = 1'b1;
        write_enable = 1'b1;
        gpio_pin     = 8'h66;
        push_ev(cyc + 1, 1'b0, 1'b0, 1'b1, 3'd4);
        idle(1);
        nn_busy = 1'b0;
        idle(1);
        chk("busy_conf_code", 32'(err_code), 32'd4);
        chk("busy_conf_state", 32'(dbg_state), 32'd0);

        // asynchronous reset mid-frame
        send(SYNC); send(8'h00); send(8'h02);
        @(negedge pi_clk);
        write_enable = 1'b0;
        rst_n        = 1'b1;
        #1;
        chk("midrst_busy", 32'(loader_busy), 32'd0);
        chk("midrst_code", 32'(err_code), 32'd0);
        @(negedge pi_clk);
        rst_n = 1'b0;
        idle(1);

        // random back-to-back frames, one with a bad checksum
        for (int k = 0; k < 6; k++) begin
            a   = $urandom_range(0, 15);
            len = $urandom_range(1, 16 - a);
            go  = 1'($urandom_range(0, 1));
            for (int i = 0; i < 16; i++) pl[i] = 8'($urandom_range(0, 255));
            frame({go, 3'b000, 4'(a)}, len, pl, (k == 2));
        end
        idle(3);

        chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
        chk("ev_q_drained", 32'(ev_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
